jtag_tap_responder: RTL

//  Target-side JTAG TAP controller: the responder on the TCK/TMS/TDI/TRST_N/TDO wires our buffer drives.
//  TCK is oversampled on the system clock. The block provides BYPASS, IDCODE and one USER data register.

---
 rtl/jtag_tap_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP (BYPASS, IDCODE, one USER DR) with TCK/TMS/TDI/TRST_N oversampled on clk_i.
// TDO follows a TCK pin fall by 3-4 clk_i; TCK high and low phases must each last at least 3 clk_i.
module jtag_tap_responder #(
    parameter int              IR_W     = 4,
    parameter logic [31:0]     IDCODE   = 32'h3F0F0F0F,
    parameter int              USER_W   = 32,
    parameter logic [IR_W-1:0] I_IDCODE = 4'b1110,
    parameter logic [IR_W-1:0] I_USER   = 4'b1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tck_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    input  logic              trst_n_i,
    output logic              tdo_o,
    output logic              tdo_oe_o,
    output logic [3:0]        tap_state_o,
    output logic [IR_W-1:0]   ir_out_o,
    output logic [USER_W-1:0] user_data_o,
    output logic              user_update_o
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic       tck_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_sync_q  <= 2'b00;
            tms_sync_q  <= 2'b11;
            tdi_sync_q  <= 2'b00;
            trst_sync_q <= 2'b00;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[0], tck_i};
            tms_sync_q  <= {tms_sync_q[0], tms_i};
            tdi_sync_q  <= {tdi_sync_q[0], tdi_i};
            trst_sync_q <= {trst_sync_q[0], trst_n_i};
            tck_prev_q  <= tck_sync_q[1];
        end
    end

    logic tck_rise, tck_fall, tms_s, tdi_s, tap_rst;
    assign tck_rise = tck_sync_q[1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[1] & tck_prev_q;
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];
    assign tap_rst  = ~trst_sync_q[1];

    tap_state_e        state_q, state_d, state_nxt;
    logic [IR_W-1:0]   ir_sr_q, ir_sr_d, ir_q, ir_d;
    logic [31:0]       idcode_sr_q, idcode_sr_d;
    logic [USER_W-1:0] user_sr_q, user_sr_d, user_data_q, user_data_d;
    logic              byp_q, byp_d;
    logic              tdo_q, tdo_d, tdo_oe_q, tdo_oe_d, user_update_q, user_update_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= TLR;
            ir_sr_q       <= '0;
            ir_q          <= I_IDCODE;
            idcode_sr_q   <= '0;
            user_sr_q     <= '0;
            user_data_q   <= '0;
            byp_q         <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
            user_update_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_sr_q       <= ir_sr_d;
            ir_q          <= ir_d;
            idcode_sr_q   <= idcode_sr_d;
            user_sr_q     <= user_sr_d;
            user_data_q   <= user_data_d;
            byp_q         <= byp_d;
            tdo_q         <= tdo_d;
            tdo_oe_q      <= tdo_oe_d;
            user_update_q <= user_update_d;
        end
    end

    always_comb begin
        state_nxt = TLR;
        case (state_q)
            TLR:     state_nxt = tms_s ? TLR    : RTI;
            RTI:     state_nxt = tms_s ? SEL_DR : RTI;
            SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
            SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // Opcodes other than IDCODE and USER (including all-ones) land on BYPASS.
    logic sel_idcode, sel_user, dr_lsb;
    assign sel_idcode = (ir_q == I_IDCODE);
    assign sel_user   = (ir_q == I_USER);
    assign dr_lsb     = sel_idcode ? idcode_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);

    always_comb begin
        state_d       = state_q;
        ir_sr_d       = ir_sr_q;
        ir_d          = ir_q;
        idcode_sr_d   = idcode_sr_q;
        user_sr_d     = user_sr_q;
        user_data_d   = user_data_q;
        byp_d         = byp_q;
        tdo_d         = tdo_q;
        tdo_oe_d      = tdo_oe_q;
        user_update_d = 1'b0;

        if (tap_rst) begin
            state_d     = TLR;
            ir_sr_d     = '0;
            idcode_sr_d = '0;
            user_sr_d   = '0;
            byp_d       = 1'b0;
            tdo_d       = 1'b0;
            tdo_oe_d    = 1'b0;
        end else if (tck_rise) begin
            case (state_q)
                CAP_IR: ir_sr_d = IR_W'(2'b01);
                SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_W-1:1]};
                CAP_DR: begin
                    byp_d       = 1'b0;
                    idcode_sr_d = IDCODE;
                    user_sr_d   = user_data_q;
                end
                SH_DR: begin
                    if (sel_idcode)    idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
                    else if (sel_user) user_sr_d = (user_sr_q >> 1) | (USER_W'(tdi_s) << (USER_W - 1));
                    else               byp_d = tdi_s;
                end
                default: ;
            endcase
            state_d = state_nxt;
        end else if (tck_fall) begin
            tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
            tdo_d    = (state_q == SH_IR) ? ir_sr_q[0] : ((state_q == SH_DR) ? dr_lsb : 1'b0);
            if (state_q == UPD_IR) ir_d = ir_sr_q;
            if (state_q == UPD_DR && sel_user) begin
                user_data_d   = user_sr_q;
                user_update_d = 1'b1;
            end
        end

        if (tap_rst || state_q == TLR) ir_d = I_IDCODE;
    end

    assign tdo_o         = tdo_q;
    assign tdo_oe_o      = tdo_oe_q;
    assign tap_state_o   = state_q;
    assign ir_out_o      = ir_q;
    assign user_data_o   = user_data_q;
    assign user_update_o = user_update_q;

endmodule
